// File: rtl/keypad_pmod_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, samples the rows,
// and debounces whole scan frames into a single hex key code with press/release events.
module keypad_pmod_scanner #(
    parameter int CLK_PER        = 10,
    parameter int SCAN_RATE      = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       key_release
);

    localparam int DWELL = 1_000_000_000 / (CLK_PER * SCAN_RATE);
    localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [3:0]    DEB        = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_PEND = 2'd1,
        HELD       = 2'd2
    } state_t;

    logic [3:0]    row_meta_r;
    logic [3:0]    row_sync_r;
    logic [DW-1:0] dwell_r;
    logic [1:0]    col_idx_r;
    logic [11:0]   acc_r;
    state_t        state_r;
    logic [3:0]    latched_r;
    logic [3:0]    deb_cnt_r;

    logic          tick_s;
    logic          frame_end_s;
    logic [1:0]    col_idx_next_s;
    logic [15:0]   hits_s;
    logic [4:0]    hit_cnt_s;
    logic [3:0]    cand_code_s;
    logic          cand_key_s;
    logic [3:0]    deb_inc_s;

    // Matrix position {col, row} to hex legend printed on the keypad
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h4;
            4'd2:    code = 4'h7;
            4'd3:    code = 4'h0;
            4'd4:    code = 4'h2;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h8;
            4'd7:    code = 4'hF;
            4'd8:    code = 4'h3;
            4'd9:    code = 4'h6;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hE;
            4'd12:   code = 4'hA;
            4'd13:   code = 4'hB;
            4'd14:   code = 4'hC;
            4'd15:   code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Frame evaluation: column 3 is taken live so the decision lands on its capture cycle
    always_comb begin
        tick_s         = (dwell_r == DWELL_LAST);
        frame_end_s    = tick_s && (col_idx_r == 2'd3);
        col_idx_next_s = col_idx_r + 2'd1;
        hits_s         = {~row_sync_r, acc_r};
        hit_cnt_s      = 5'd0;
        cand_code_s    = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (hits_s[i]) begin
                hit_cnt_s   = hit_cnt_s + 5'd1;
                cand_code_s = key_map(4'(i));
            end else begin
                hit_cnt_s   = hit_cnt_s;
            end
        end
        cand_key_s = (hit_cnt_s == 5'd1);
        deb_inc_s  = deb_cnt_r + 4'd1;
    end

    // Row synchronizer, free-running dwell/column scan and per-frame row capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
            dwell_r    <= '0;
            col_idx_r  <= 2'd0;
            col        <= 4'b1110;
            acc_r      <= 12'd0;
        end else begin
            row_meta_r <= row;
            row_sync_r <= row_meta_r;
            if (tick_s) begin
                dwell_r   <= '0;
                col_idx_r <= col_idx_next_s;
                col       <= ~(4'b0001 << col_idx_next_s);
                case (col_idx_r)
                    2'd0:    acc_r[3:0]  <= ~row_sync_r;
                    2'd1:    acc_r[7:4]  <= ~row_sync_r;
                    2'd2:    acc_r[11:8] <= ~row_sync_r;
                    default: acc_r       <= acc_r;
                endcase
            end else begin
                dwell_r <= dwell_r + 1'b1;
            end
        end
    end

    // Debounce FSM, stepped once per frame; all key outputs registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= RELEASED;
            latched_r   <= 4'h0;
            deb_cnt_r   <= 4'd0;
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_down    <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (frame_end_s) begin
                case (state_r)
                    RELEASED: begin
                        if (cand_key_s) begin
                            latched_r <= cand_code_s;
                            if (DEB <= 4'd1) begin
                                state_r   <= HELD;
                                deb_cnt_r <= 4'd0;
                                key_code  <= cand_code_s;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                            end else begin
                                state_r   <= PRESS_PEND;
                                deb_cnt_r <= 4'd1;
                            end
                        end else begin
                            deb_cnt_r <= 4'd0;
                        end
                    end
                    PRESS_PEND: begin
                        if (cand_key_s && (cand_code_s == latched_r)) begin
                            if (deb_inc_s >= DEB) begin
                                state_r   <= HELD;
                                deb_cnt_r <= 4'd0;
                                key_code  <= latched_r;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                            end else begin
                                deb_cnt_r <= deb_inc_s;
                            end
                        end else if (cand_key_s) begin
                            latched_r <= cand_code_s;
                            deb_cnt_r <= 4'd1;
                        end else begin
                            state_r   <= RELEASED;
                            deb_cnt_r <= 4'd0;
                        end
                    end
                    HELD: begin
                        if (cand_key_s && (cand_code_s == key_code)) begin
                            deb_cnt_r <= 4'd0;
                        end else if (deb_inc_s >= DEB) begin
                            state_r     <= RELEASED;
                            deb_cnt_r   <= 4'd0;
                            key_down    <= 1'b0;
                            key_release <= 1'b1;
                        end else begin
                            deb_cnt_r <= deb_inc_s;
                        end
                    end
                    default: begin
                        state_r   <= RELEASED;
                        deb_cnt_r <= 4'd0;
                        key_down  <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_keypad_pmod_scanner.sv
// Directed bench for keypad_pmod_scanner: behavioural keypad matrix, frame-aligned key presses,
// DWELL=10 so one frame is 40 cycles and frame F ends at cycle 40*F.
module tb_keypad_pmod_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       key_release;

    logic [15:0] keys;
    int total;
    int bad;
    int cyc;
    int valid_cnt;
    int rel_cnt;
    int last_valid_cyc;
    int last_rel_cyc;
    logic [3:0] last_valid_code;
    logic down_seen;

    localparam logic [15:0] K1  = 16'h0001;
    localparam logic [15:0] K2  = 16'h0010;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K7  = 16'h0004;
    localparam logic [15:0] K8  = 16'h0040;
    localparam logic [15:0] K9  = 16'h0400;
    localparam logic [15:0] KA  = 16'h1000;
    localparam logic [15:0] KD  = 16'h8000;

    keypad_pmod_scanner #(
        .CLK_PER(10),
        .SCAN_RATE(10_000_000),
        .DEBOUNCE_SCANS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_down(key_down),
        .key_release(key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // keypad matrix: a pressed key at bit c*4+r pulls row r low while column c is driven low
    always_comb begin
        row = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (key_valid) begin
                valid_cnt       <= valid_cnt + 1;
                last_valid_cyc  <= cyc;
                last_valid_code <= key_code;
            end
            if (key_release) begin
                rel_cnt      <= rel_cnt + 1;
                last_rel_cyc <= cyc;
            end
            if (key_down) down_seen <= 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_col;
        total = 0; bad = 0;
        valid_cnt = 0; rel_cnt = 0;
        last_valid_cyc = -1; last_rel_cyc = -1;
        last_valid_code = 4'h0; down_seen = 1'b0;
        keys = 16'h0000;
        reset = 1'b1;
        #3;
        check("rst_col", 32'(col), 32'(4'b1110));
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_down", 32'(key_down), 32'h0);
        check("rst_release", 32'(key_release), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: idle scan sequence across the first frame and the wrap
        for (int t = 0; t < 45; t++) begin
            goto(t);
            exp_col = ~(4'b0001 << ((t / 10) % 4));
            check("scan_col", 32'(col), 32'(exp_col));
        end
        goto(800);
        check("idle_valid", 32'(valid_cnt), 32'd0);
        check("idle_release", 32'(rel_cnt), 32'd0);
        check("idle_down", 32'(down_seen), 32'd0);

        // 2: key 5 for frames 21..30, accepted at frame 24 end
        keys = K5;
        goto(959);
        check("k5_early", 32'(valid_cnt), 32'd0);
        goto(960);
        check("k5_valid_cnt", 32'(valid_cnt), 32'd1);
        check("k5_valid_cyc", 32'(last_valid_cyc), 32'd960);
        check("k5_code", 32'(last_valid_code), 32'h5);
        goto(961);
        check("k5_pulse_width", 32'(key_valid), 32'd0);
        goto(1200);
        check("k5_down", 32'(key_down), 32'd1);
        check("k5_single", 32'(valid_cnt), 32'd1);
        keys = 16'h0000;
        goto(1360);
        check("k5_rel_cnt", 32'(rel_cnt), 32'd1);
        check("k5_rel_cyc", 32'(last_rel_cyc), 32'd1360);
        goto(1361);
        check("k5_rel_width", 32'(key_release), 32'd0);
        check("k5_up", 32'(key_down), 32'd0);

        // 3: key 9 for 3 frames, gap, then 4 frames (39..42)
        keys = K9;
        goto(1480);
        keys = 16'h0000;
        goto(1520);
        check("k9_short", 32'(valid_cnt), 32'd1);
        keys = K9;
        goto(1680);
        check("k9_valid_cnt", 32'(valid_cnt), 32'd2);
        check("k9_valid_cyc", 32'(last_valid_cyc), 32'd1680);
        check("k9_code", 32'(last_valid_code), 32'h9);
        keys = 16'h0000;
        goto(1840);
        check("k9_rel_cyc", 32'(last_rel_cyc), 32'd1840);

        // 4: ghosting pair 1+2, then 7 accepted and 8 added
        keys = K1 | K2;
        goto(2160);
        check("multi_no_valid", 32'(valid_cnt), 32'd2);
        keys = K7;
        goto(2320);
        check("k7_valid_cnt", 32'(valid_cnt), 32'd3);
        check("k7_code", 32'(last_valid_code), 32'h7);
        keys = K7 | K8;
        goto(2479);
        check("k78_hold", 32'(key_down), 32'd1);
        goto(2480);
        check("k78_rel_cnt", 32'(rel_cnt), 32'd3);
        check("k78_rel_cyc", 32'(last_rel_cyc), 32'd2480);
        goto(2485);
        check("k78_code_kept", 32'(key_code), 32'h7);
        goto(2640);
        check("k78_no_valid", 32'(valid_cnt), 32'd3);
        keys = 16'h0000;

        // 5: key D accepted, then released
        keys = KD;
        goto(2800);
        check("kd_valid_cnt", 32'(valid_cnt), 32'd4);
        check("kd_code", 32'(last_valid_code), 32'hD);
        goto(2880);
        keys = 16'h0000;
        goto(3039);
        check("kd_rel_early", 32'(rel_cnt), 32'd3);
        goto(3040);
        check("kd_rel_cyc", 32'(last_rel_cyc), 32'd3040);
        goto(3041);
        check("kd_up", 32'(key_down), 32'd0);
        check("kd_code_kept", 32'(key_code), 32'hD);

        // 6: reset during PRESS_PEND for key A
        keys = KA;
        goto(3130);
        reset = 1'b1;
        #1;
        check("mid_rst_col", 32'(col), 32'(4'b1110));
        check("mid_rst_code", 32'(key_code), 32'h0);
        check("mid_rst_down", 32'(key_down), 32'h0);
        check("mid_rst_valid", 32'(key_valid), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        goto(159);
        check("ka_early", 32'(valid_cnt), 32'd4);
        goto(160);
        check("ka_valid_cnt", 32'(valid_cnt), 32'd5);
        check("ka_valid_cyc", 32'(last_valid_cyc), 32'd160);
        check("ka_code", 32'(last_valid_code), 32'hA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
